// File: rtl/pulse_sequencer_if.sv
// pulse_sequencer_if: pulse-parameter registers in, RF/inhibit/sync gates out
interface pulse_sequencer_if;
  logic [31:0] per;
  logic [7:0] nut_w, cp, p_bl;
  logic [15:0] nut_d, p1wid, del, p2wid;
  logic bl, pulse, inhib, sync;
  modport master(output per, nut_w, nut_d, p1wid, del, p2wid, cp, bl, p_bl, input pulse, inhib, sync);
  modport slave(input per, nut_w, nut_d, p1wid, del, p2wid, cp, bl, p_bl, output pulse, inhib, sync);
endinterface

// File: rtl/pulse_sequencer.sv
// pulse_sequencer: repeating spin-echo / CPMG pulse train with per-period parameter snapshot
module pulse_sequencer #(
  parameter int MIN_PER = 2
) (
  input logic clk,
  input logic resetn,
  pulse_sequencer_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, NUT = 3'd1, NGAP = 3'd2, P1 = 3'd3, GAP1 = 3'd4, P2 = 3'd5, CGAP = 3'd6;
  logic run, s_bl, e_bl, wrap, adv, pulse_r, pulse_n, inhib_r, sync_r;
  logic [31:0] pcnt, pcnt_n, s_per, e_per, per_s, per_e;
  logic [15:0] s_nut_d, s_p1wid, s_del, s_p2wid, e_nut_d, e_p1wid, e_del, e_p2wid;
  logic [7:0] s_nut_w, s_cp, s_p_bl, e_nut_w, e_cp, e_p_bl, rep, r, bc, bc_n;
  logic [2:0] st, nx;
  logic [16:0] cnt, len;
  assign per_s = (s_per < 32'(MIN_PER)) ? 32'(MIN_PER) : s_per;
  assign wrap = !run || pcnt == per_s - 32'd1;
  // on the snapshot edge the new train is planned straight from the inputs being captured
  assign e_per = wrap ? bus.per : s_per;
  assign e_nut_w = wrap ? bus.nut_w : s_nut_w;
  assign e_nut_d = wrap ? bus.nut_d : s_nut_d;
  assign e_p1wid = wrap ? bus.p1wid : s_p1wid;
  assign e_del = wrap ? bus.del : s_del;
  assign e_p2wid = wrap ? bus.p2wid : s_p2wid;
  assign e_cp = wrap ? bus.cp : s_cp;
  assign e_bl = wrap ? bus.bl : s_bl;
  assign e_p_bl = wrap ? bus.p_bl : s_p_bl;
  assign per_e = (e_per < 32'(MIN_PER)) ? 32'(MIN_PER) : e_per;
  assign pcnt_n = wrap ? 32'd0 : pcnt + 32'd1;
  assign adv = wrap || (st != IDLE && cnt == 17'd1);
  // rep counts P2 entries still owed, including the one in progress
  always_comb begin
    nx = wrap ? NUT : !adv ? st : st == P2 ? (rep > 8'd1 ? CGAP : IDLE) : st == CGAP ? P2 : st == IDLE ? IDLE : st + 3'd1;
    r = (!wrap && adv && st == P2) ? rep - 8'd1 : rep;
    if (nx == NUT && e_nut_w == 8'd0) nx = P1;
    if (nx == NGAP && e_nut_d == 16'd0) nx = P1;
    if (nx == P1 && e_p1wid == 16'd0) nx = GAP1;
    if (nx == GAP1) r = e_cp;
    if (nx == GAP1 && (e_cp == 8'd0 || e_del == 16'd0)) nx = e_cp == 8'd0 ? IDLE : P2;
    if (nx == P2 && e_p2wid == 16'd0) begin
      nx = (r > 8'd1 && e_del != 16'd0) ? CGAP : IDLE;
      r = r - 8'd1;
    end
    if (nx == CGAP && e_del == 16'd0) nx = e_p2wid != 16'd0 ? P2 : IDLE;
    len = nx == NUT ? 17'(e_nut_w) : nx == NGAP ? 17'(e_nut_d) : nx == P1 ? 17'(e_p1wid) :
          nx == GAP1 ? 17'(e_del) : nx == P2 ? 17'(e_p2wid) : nx == CGAP ? {e_del, 1'b0} : 17'd0;
  end
  // the last cycle of every period is forced low so a truncated train always shows a falling edge
  assign pulse_n = (nx == NUT || nx == P2 || (nx == P1 && e_bl)) && pcnt_n != per_e - 32'd1;
  assign bc_n = (pulse_r && !pulse_n) ? e_p_bl : bc - 8'(bc != 8'd0);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {run, pcnt, st, cnt, rep, bc, pulse_r, inhib_r, sync_r} <= '0;
      {s_per, s_nut_w, s_nut_d, s_p1wid, s_del, s_p2wid, s_cp, s_bl, s_p_bl} <= '0;
    end else begin
      run <= 1'b1;
      pcnt <= pcnt_n;
      st <= nx;
      cnt <= adv ? len : cnt - 17'd1;
      rep <= r;
      bc <= bc_n;
      pulse_r <= pulse_n;
      inhib_r <= pulse_n || bc_n != 8'd0;
      sync_r <= wrap;
      if (wrap) {s_per, s_nut_w, s_nut_d, s_p1wid, s_del, s_p2wid, s_cp, s_bl, s_p_bl} <=
        {bus.per, bus.nut_w, bus.nut_d, bus.p1wid, bus.del, bus.p2wid, bus.cp, bus.bl, bus.p_bl};
    end
  assign bus.pulse = pulse_r;
  assign bus.inhib = inhib_r;
  assign bus.sync = sync_r;
endmodule

// File: tb/tb_pulse_sequencer.sv
// tb_pulse_sequencer: test-plan windows plus randomized parameter churn against a period-level model
module tb_pulse_sequencer;
  logic clk = 1'b0, resetn = 1'b0;
  int n_chk = 0, n_pass = 0;
  bit exp_p [0:255];
  int pos = 0, per_s = 2, now = 0, tf = -1000, fall_bl = 0, pbl_cur = 0;
  bit started = 1'b0, prev_p = 1'b0;
  logic [63:0] tp, ti, ts, mp, ms;

  pulse_sequencer_if bus();
  pulse_sequencer #(.MIN_PER(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, now);
  endtask

  task automatic setp(input int per, nw, nd, p1, d, p2, c, b, pb);
    bus.per = per;
    bus.nut_w = 8'(nw);
    bus.nut_d = 16'(nd);
    bus.p1wid = 16'(p1);
    bus.del = 16'(d);
    bus.p2wid = 16'(p2);
    bus.cp = 8'(c);
    bus.bl = b != 0;
    bus.p_bl = 8'(pb);
  endtask

  task automatic rnd(input int f);
    case (f)
      0: bus.per = $urandom_range(0, 60);
      1: bus.nut_w = 8'($urandom_range(0, 4));
      2: bus.nut_d = 16'($urandom_range(0, 5));
      3: bus.p1wid = 16'($urandom_range(0, 5));
      4: bus.del = 16'($urandom_range(0, 4));
      5: bus.p2wid = 16'($urandom_range(0, 4));
      6: bus.cp = 8'($urandom_range(0, 4));
      7: bus.bl = 1'($urandom_range(0, 1));
      default: bus.p_bl = 8'($urandom_range(0, 6));
    endcase
  endtask

  task automatic model_reset();
    started = 1'b0;
    prev_p = 1'b0;
    tf = -1000;
    fall_bl = 0;
  endtask

  task automatic mark(input int s, input int w);
    for (int i = s; i < s + w; i++) if (i < per_s - 1 && i < 256) exp_p[i] = 1'b1;
  endtask

  // whole-period plan: list the high intervals from the snapshot, clip at the period's last cycle
  task automatic plan();
    int t;
    t = 0;
    per_s = (bus.per < 2) ? 2 : int'(bus.per);
    foreach (exp_p[i]) exp_p[i] = 1'b0;
    if (bus.nut_w != 0) begin
      mark(0, int'(bus.nut_w));
      t = int'(bus.nut_w) + int'(bus.nut_d);
    end
    if (bus.bl) mark(t, int'(bus.p1wid));
    t += int'(bus.p1wid);
    if (bus.cp != 0) begin
      t += int'(bus.del);
      for (int k = 0; k < int'(bus.cp); k++) begin
        mark(t, int'(bus.p2wid));
        t += int'(bus.p2wid) + 2 * int'(bus.del);
      end
    end
    pbl_cur = int'(bus.p_bl);
  endtask

  task automatic step();
    bit ep, ei;
    if (!started || pos == per_s - 1) begin
      started = 1'b1;
      pos = 0;
      plan();
    end else pos++;
    ep = exp_p[pos];
    if (prev_p && !ep) begin
      tf = now;
      fall_bl = pbl_cur;
    end
    ei = ep || (now - tf < fall_bl);
    chk("pulse", 64'(bus.pulse), 64'(ep));
    chk("inhib", 64'(bus.inhib), 64'(ei));
    chk("sync", 64'(bus.sync), 64'(pos == 0));
    prev_p = ep;
    now++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    step();
  endtask

  task automatic align();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (pos != 0 && k < 400);
    if (pos != 0) chk("align_timeout", 64'(pos), 64'd0);
  endtask

  task automatic window(input int chg_at);
    align();
    for (int i = 0; i < 64; i++) begin
      if (i > 0) tick();
      tp[i] = bus.pulse;
      ti[i] = bus.inhib;
      ts[i] = bus.sync;
      if (i == chg_at) bus.p2wid = 16'd9;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    setp(100, 0, 0, 3, 5, 6, 1, 1, 4);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pulse", 64'(bus.pulse), 64'd0);
    chk("rst_inhib", 64'(bus.inhib), 64'd0);
    chk("rst_sync", 64'(bus.sync), 64'd0);
    model_reset();
    #1 resetn = 1'b1;
    window(-1);
    chk("basic_pulse", tp, 64'h3F07);
    chk("basic_inhib", ti, 64'h3FF7F);
    chk("basic_sync", ts, 64'h1);
    setp(100, 0, 0, 2, 4, 2, 3, 1, 0);
    window(-1);
    chk("cpmg_pulse", tp, 64'h0C0300C3);
    chk("cpmg_inhib", ti, 64'h0C0300C3);
    setp(100, 5, 10, 4, 3, 2, 1, 0, 2);
    window(-1);
    chk("nut_pulse", tp, 64'h00C0001F);
    chk("nut_inhib", ti, 64'h03C0007F);
    setp(10, 0, 0, 20, 0, 0, 0, 1, 0);
    window(-1);
    for (int i = 0; i < 64; i++) begin
      mp[i] = (i % 10) != 9;
      ms[i] = (i % 10) == 0;
    end
    chk("trunc_pulse", tp, mp);
    chk("trunc_sync", ts, ms);
    setp(0, 0, 0, 20, 0, 0, 0, 1, 0);
    window(-1);
    for (int i = 0; i < 64; i++) ms[i] = (i % 2) == 0;
    chk("clamp_sync", ts, ms);
    chk("clamp_pulse", tp, ms);
    setp(40, 0, 0, 3, 5, 6, 1, 1, 4);
    window(4);
    chk("upd_pulse", tp, 64'h01FF_0700_0000_3F07);
    chk("upd_inhib", ti, 64'h1FFF_7F00_0003_FF7F);
    chk("upd_sync", ts, 64'h0000_0100_0000_0001);
    setp(100, 0, 0, 3, 5, 6, 1, 1, 4);
    align();
    repeat (9) tick();
    #3 resetn = 1'b0;
    #1;
    chk("arst_pulse", 64'(bus.pulse), 64'd0);
    chk("arst_inhib", 64'(bus.inhib), 64'd0);
    chk("arst_sync", 64'(bus.sync), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    tick();
    chk("arst_first_sync", 64'(bus.sync), 64'd1);
    chk("arst_first_pulse", 64'(bus.pulse), 64'd1);
    for (int n = 0; n < 40; n++) begin
      for (int f = 0; f < 9; f++) rnd(f);
      repeat ($urandom_range(20, 120)) begin
        tick();
        if ($urandom_range(0, 5) == 0) rnd(int'($urandom_range(0, 8)));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
